// File: rtl/iir_pkg.sv
// iir_pkg: shared constants, FSM state and sizing helpers for the multi-channel biquad.
package iir_pkg;
   localparam logic [2:0] IDX_B0 = 3'd0, IDX_B1 = 3'd1, IDX_B2 = 3'd2, IDX_A1 = 3'd3, IDX_A2 = 3'd4;
   typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
   function automatic int acc_w(int data_w, int coef_w);
      return data_w + coef_w + 3;
   endfunction
   function automatic int ch_w(int num_ch);
      return num_ch > 1 ? $clog2(num_ch) : 1;
   endfunction
   // Passthrough: b0 = 1.0, everything else 0.
   function automatic logic [31:0] coef_rst(int idx, int frac);
      return idx == 32'(IDX_B0) ? 32'd1 << frac : 32'd0;
   endfunction
endpackage

// File: rtl/iir_mac_unit.sv
// iir_mac_unit: shared multiplier, add/subtract accumulator and round/reduce stage.
// Saturation instead of wrap when IIR_SAT_EN is defined.
module iir_mac_unit import iir_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int COEF_FRAC = 14,
   localparam int AW = acc_w(DATA_W, COEF_W)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic                     sub_i,
   input  logic signed [COEF_W-1:0] coef_i,
   input  logic signed [DATA_W-1:0] data_i,
   output logic signed [DATA_W-1:0] y_o,
   output logic                     ovf_o
);
   localparam logic signed [AW-1:0] HALF = AW'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [AW-1:0] MAXV = AW'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
   logic signed [AW-1:0] acc_q, acc_d, prod, rnd;
   always_comb begin
      prod  = AW'(coef_i) * AW'(data_i);
      acc_d = clr_i ? '0 : en_i ? (sub_i ? acc_q - prod : acc_q + prod) : acc_q;
      // Result is taken from the next accumulator value so it is ready as HOLD is entered.
      rnd   = (acc_d + HALF) >>> COEF_FRAC;
      ovf_o = rnd > MAXV || rnd < MINV;
`ifdef IIR_SAT_EN
      y_o   = rnd > MAXV ? MAXV[DATA_W-1:0] : rnd < MINV ? MINV[DATA_W-1:0] : rnd[DATA_W-1:0];
`else
      y_o   = rnd[DATA_W-1:0];
`endif
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: NUM_CH-channel Direct-Form-I biquad with one time-shared MAC.
// Optional macro IIR_SAT_EN selects saturation of the reduced result.
module iir_biquad_mc import iir_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int COEF_FRAC = 14,
   parameter int NUM_CH = 4,
   localparam int CH_W = ch_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [DATA_W-1:0] out_data,
   input  logic                     coef_we,
   input  logic [CH_W-1:0]          coef_ch,
   input  logic [2:0]               coef_idx,
   input  logic signed [COEF_W-1:0] coef_wdata,
   input  logic                     state_clr,
   output logic                     ovf
);
   state_t                   state_q;
   logic [2:0]               step_q;
   logic [CH_W-1:0]          ch_q;
   logic signed [DATA_W-1:0] out_data_q, mac_y;
   logic                     ovf_q, mac_ovf, accept;
   logic signed [COEF_W-1:0] coef_q [NUM_CH][5];
   // Per channel: x1, x2, y1, y2
   logic signed [DATA_W-1:0] hist_q [NUM_CH][4];
   // Snapshot operands in MAC order: (b0,x) (b1,x1) (b2,x2) (a1,y1) (a2,y2)
   logic signed [COEF_W-1:0] sc_q [5];
   logic signed [DATA_W-1:0] sd_q [5];
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == HOLD;
   assign out_ch    = ch_q;
   assign out_data  = out_data_q;
   assign ovf       = ovf_q;
   // Out-of-range channels are taken off the bus but never enter MAC.
   assign accept    = in_ready && in_valid && !state_clr && 32'(in_ch) < NUM_CH;
   iir_mac_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_mac (
      .clk(clk), .reset(reset), .clr_i(accept), .en_i(state_q == MAC),
      .sub_i(step_q >= IDX_A1), .coef_i(sc_q[step_q]), .data_i(sd_q[step_q]),
      .y_o(mac_y), .ovf_o(mac_ovf)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 5; i++) coef_q[c][i] <= COEF_W'(coef_rst(i, COEF_FRAC));
      end else if (coef_we && 32'(coef_ch) < NUM_CH && coef_idx <= IDX_A2) begin
         coef_q[coef_ch][coef_idx] <= coef_wdata;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q    <= IDLE;
         step_q     <= '0;
         ch_q       <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            sc_q[i] <= '0;
            sd_q[i] <= '0;
         end
         for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 4; i++) hist_q[c][i] <= '0;
      end else begin
         ovf_q <= 1'b0;
         if (state_clr) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int c = 0; c < NUM_CH; c++)
               for (int i = 0; i < 4; i++) hist_q[c][i] <= '0;
         end else begin
            case (state_q)
               IDLE: if (accept) begin
                  ch_q    <= in_ch;
                  sd_q[0] <= in_data;
                  for (int i = 0; i < 5; i++) sc_q[i] <= coef_q[in_ch][i];
                  for (int i = 0; i < 4; i++) sd_q[i+1] <= hist_q[in_ch][i];
                  step_q  <= '0;
                  state_q <= MAC;
               end
               MAC: begin
                  step_q <= step_q == IDX_A2 ? 3'd0 : step_q + 3'd1;
                  if (step_q == IDX_A2) begin
                     state_q    <= HOLD;
                     out_data_q <= mac_y;
                     ovf_q      <= mac_ovf;
                  end
               end
               HOLD: if (out_ready) begin
                  hist_q[ch_q][0] <= sd_q[0];
                  hist_q[ch_q][1] <= sd_q[1];
                  hist_q[ch_q][2] <= out_data_q;
                  hist_q[ch_q][3] <= sd_q[3];
                  state_q         <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb_iir_biquad_mc: directed and random checks of iir_biquad_mc against an arithmetic model.
// Expects the saturated result when compiled with IIR_SAT_EN.
module tb_iir_biquad_mc;
   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [1:0] in_ch = '0, out_ch, coef_ch = '0;
   logic signed [15:0] in_data = '0, out_data, coef_wdata = '0;
   logic coef_we = 1'b0, state_clr = 1'b0, ovf;
   logic [2:0] coef_idx = '0;
   int total = 0, bad = 0;
   int cf [4][5];
   int hx1 [4], hx2 [4], hy1 [4], hy2 [4];
   int last_y;

   iir_biquad_mc dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_data(out_data), .coef_we(coef_we), .coef_ch(coef_ch), .coef_idx(coef_idx),
      .coef_wdata(coef_wdata), .state_clr(state_clr), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic longint model_raw(int ch, int x);
      longint acc;
      acc = longint'(cf[ch][0]) * x + longint'(cf[ch][1]) * hx1[ch] + longint'(cf[ch][2]) * hx2[ch]
          - longint'(cf[ch][3]) * hy1[ch] - longint'(cf[ch][4]) * hy2[ch];
      return (acc + 8192) >>> 14;
   endfunction

   function automatic int reduce(longint r);
`ifdef IIR_SAT_EN
      return r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
`else
      return int'(shortint'(r));
`endif
   endfunction

   task automatic clear_model();
      for (int c = 0; c < 4; c++) begin
         hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0;
      end
   endtask

   task automatic write_coef(input int ch, input int idx, input int v);
      @(negedge clk);
      coef_we = 1'b1; coef_ch = 2'(ch); coef_idx = 3'(idx); coef_wdata = 16'(v);
      @(negedge clk);
      coef_we = 1'b0;
      if (idx < 5) cf[ch][idx] = v;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      state_clr = 1'b1;
      @(negedge clk);
      state_clr = 1'b0;
      clear_model();
   endtask

   // One sample end to end; optionally rewrites a coefficient of the same channel mid-flight.
   task automatic send(input int ch, input int x, input int hold, input bit mid_wr);
      longint r;
      int exp_y, cyc, nov, wi, wv, stable;
      bit exp_ovf;
      logic signed [15:0] d0;
      logic [1:0] c0;
      r = model_raw(ch, x);
      exp_y = reduce(r);
      exp_ovf = r > 32767 || r < -32768;
      wi = int'($urandom_range(0, 4));
      wv = int'($urandom_range(0, 65535)) - 32768;
      @(negedge clk);
      chk("in_ready_idle", longint'(in_ready), 1);
      in_valid = 1'b1; in_ch = 2'(ch); in_data = 16'(x);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1; nov = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         nov += int'(ovf);
         if (mid_wr && cyc == 2) begin
            coef_we = 1'b1; coef_ch = 2'(ch); coef_idx = 3'(wi); coef_wdata = 16'(wv);
         end else coef_we = 1'b0;
         @(negedge clk);
         cyc++;
      end
      coef_we = 1'b0;
      if (mid_wr) cf[ch][wi] = wv;
      chk("latency", cyc, 6);
      chk("out_ch", longint'(out_ch), ch);
      chk("out_data", longint'(out_data), exp_y);
      nov += int'(ovf);
      d0 = out_data; c0 = out_ch;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         nov += int'(ovf);
         stable = int'(out_data === d0 && out_ch === c0 && in_ready === 1'b0 && out_valid === 1'b1);
         chk("bp_stable", stable, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      nov += int'(ovf);
      chk("single_xfer", longint'(out_valid), 0);
      chk("ovf_pulses", nov, exp_ovf ? 1 : 0);
      last_y = int'(d0);
      hx2[ch] = hx1[ch]; hx1[ch] = x; hy2[ch] = hy1[ch]; hy1[ch] = exp_y;
   endtask

   initial begin
      int seen;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 5; i++) cf[c][i] = (i == 0) ? 16384 : 0;
      clear_model();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
      chk("rst_ovf", longint'(ovf), 0);

      send(0, 1000, 0, 0);
      chk("passthrough", last_y, 1000);

      write_coef(1, 0, 16384);
      write_coef(1, 3, -8192);
      send(1, 4096, 0, 0); chk("imp0", last_y, 4096);
      send(1, 0, 0, 0);    chk("imp1", last_y, 2048);
      send(1, 0, 0, 0);    chk("imp2", last_y, 1024);
      send(1, 0, 0, 0);    chk("imp3", last_y, 512);

      pulse_clr();
      send(1, 4096, 0, 0); chk("iso_ch1_0", last_y, 4096);
      send(0, 5, 0, 0);    chk("iso_ch0_5", last_y, 5);
      send(1, 0, 0, 0);    chk("iso_ch1_1", last_y, 2048);
      send(0, 6, 0, 0);    chk("iso_ch0_6", last_y, 6);
      send(1, 0, 0, 0);    chk("iso_ch1_2", last_y, 1024);

      write_coef(2, 0, 32767);
      write_coef(2, 6, 1234);
      send(2, 30000, 0, 0);
`ifdef IIR_SAT_EN
      chk("ovf_value", last_y, 32767);
`else
      chk("ovf_value", last_y, -5538);
`endif

      send(3, int'($urandom_range(0, 65535)) - 32768, 10, 0);

      // Abort during the third MAC cycle
      @(negedge clk);
      in_valid = 1'b1; in_ch = 2'd1; in_data = 16'sd777;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      state_clr = 1'b1;
      @(negedge clk);
      state_clr = 1'b0;
      clear_model();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         seen += int'(out_valid);
         @(negedge clk);
      end
      chk("abort_no_out", seen, 0);
      send(1, 4096, 0, 0);
      chk("abort_hist_zero", last_y, 4096);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            write_coef(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 65535)) - 32768);
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
